// File: rtl/countdown_counter_if.sv
// Control levels from the timer FSM and the BCD time/status returned to it and the display.
// Pure wiring: no storage, no latency, no backpressure.
interface countdown_counter_if;
    logic       init_regs;
    logic       count_enabled;
    logic       inc;
    logic       dec;
    logic       min;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       sec_tick;
    logic       complete;

    modport master (
        output init_regs, count_enabled, inc, dec, min,
        input  min_tens, min_ones, sec_tens, sec_ones, sec_tick, complete
    );

    modport slave (
        input  init_regs, count_enabled, inc, dec, min,
        output min_tens, min_ones, sec_tens, sec_ones, sec_tick, complete
    );
endinterface

// File: rtl/countdown_counter.sv
// MM:SS BCD countdown register with field edit and a CLK_FREQ-cycle second prescaler.
// Edits/init visible next cycle, decrement one cycle after terminal prescaler count; no backpressure.
module countdown_counter #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int INIT_MIN = 0,
    parameter int INIT_SEC = 0
) (
    input  logic               clk,
    input  logic               reset,
    countdown_counter_if.slave bus
);

    localparam int              PW       = $clog2(CLK_FREQ);
    localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_FREQ - 1);
    localparam logic [3:0]      INIT_MT  = 4'(INIT_MIN / 10);
    localparam logic [3:0]      INIT_MO  = 4'(INIT_MIN % 10);
    localparam logic [3:0]      INIT_ST  = 4'(INIT_SEC / 10);
    localparam logic [3:0]      INIT_SO  = 4'(INIT_SEC % 10);

    // Two-digit BCD field step up; wraps from {top_t,top_o} to 00.
    function automatic logic [7:0] bcd_up(input logic [7:0] f,
                                          input logic [3:0] top_t,
                                          input logic [3:0] top_o);
        logic [7:0] r;
        if (f == {top_t, top_o})   r = 8'h00;
        else if (f[3:0] == 4'd9)   r = {f[7:4] + 4'd1, 4'd0};
        else                       r = {f[7:4], f[3:0] + 4'd1};
        return r;
    endfunction

    // Two-digit BCD field step down; wraps from 00 to {top_t,top_o}.
    function automatic logic [7:0] bcd_down(input logic [7:0] f,
                                            input logic [3:0] top_t,
                                            input logic [3:0] top_o);
        logic [7:0] r;
        if (f == 8'h00)            r = {top_t, top_o};
        else if (f[3:0] == 4'd0)   r = {f[7:4] - 4'd1, 4'd9};
        else                       r = {f[7:4], f[3:0] - 4'd1};
        return r;
    endfunction

    logic [3:0]    min_tens_q, min_tens_d;
    logic [3:0]    min_ones_q, min_ones_d;
    logic [3:0]    sec_tens_q, sec_tens_d;
    logic [3:0]    sec_ones_q, sec_ones_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          sec_tick_q, sec_tick_d;
    logic          is_zero;
    logic          edit;

    assign is_zero = ({min_tens_q, min_ones_q, sec_tens_q, sec_ones_q} == 16'h0000);
    assign edit    = bus.inc ^ bus.dec;

    always_comb begin
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        pre_d      = pre_q;
        sec_tick_d = 1'b0;

        if (bus.init_regs) begin
            min_tens_d = INIT_MT;
            min_ones_d = INIT_MO;
            sec_tens_d = INIT_ST;
            sec_ones_d = INIT_SO;
            pre_d      = '0;
        end else if (edit) begin
            // Fields wrap independently: no carry or borrow between minutes and seconds.
            if (bus.min) begin
                {min_tens_d, min_ones_d} = bus.inc ? bcd_up({min_tens_q, min_ones_q}, 4'd9, 4'd9)
                                                   : bcd_down({min_tens_q, min_ones_q}, 4'd9, 4'd9);
            end else begin
                {sec_tens_d, sec_ones_d} = bus.inc ? bcd_up({sec_tens_q, sec_ones_q}, 4'd5, 4'd9)
                                                   : bcd_down({sec_tens_q, sec_ones_q}, 4'd5, 4'd9);
            end
        end else if (bus.count_enabled) begin
            if (is_zero) begin
                pre_d = '0;
            end else if (pre_q == PRE_LAST) begin
                pre_d      = '0;
                sec_tick_d = 1'b1;
                {sec_tens_d, sec_ones_d} = bcd_down({sec_tens_q, sec_ones_q}, 4'd5, 4'd9);
                // Seconds at 00 wrap to 59 and borrow one minute; minutes are nonzero here.
                if ({sec_tens_q, sec_ones_q} == 8'h00)
                    {min_tens_d, min_ones_d} = bcd_down({min_tens_q, min_ones_q}, 4'd9, 4'd9);
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            min_tens_q <= INIT_MT;
            min_ones_q <= INIT_MO;
            sec_tens_q <= INIT_ST;
            sec_ones_q <= INIT_SO;
            pre_q      <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            pre_q      <= pre_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    assign bus.min_tens = min_tens_q;
    assign bus.min_ones = min_ones_q;
    assign bus.sec_tens = sec_tens_q;
    assign bus.sec_ones = sec_ones_q;
    assign bus.sec_tick = sec_tick_q;
    assign bus.complete = is_zero;

endmodule

// File: tb/tb_countdown_counter.sv
// Directed and random stimulus for countdown_counter against a seconds-arithmetic reference model.
module tb_countdown_counter;

    localparam int CF = 10;

    logic clk = 1'b0;
    logic reset;
    countdown_counter_if bus();

    countdown_counter #(.CLK_FREQ(CF), .INIT_MIN(1), .INIT_SEC(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: time as integer minutes/seconds, phase as a cycle count within the second.
    int m_min = 1;
    int m_sec = 0;
    int m_pre = 0;
    bit m_tick = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit init, input bit cen,
                              input bit i, input bit d, input bit mn);
        int t;
        m_tick = 1'b0;
        if (rst || init) begin
            m_min = 1; m_sec = 0; m_pre = 0;
        end else if (i != d) begin
            if (mn) m_min = (m_min + (i ? 1 : 99)) % 100;
            else    m_sec = (m_sec + (i ? 1 : 59)) % 60;
        end else if (cen) begin
            if (m_min == 0 && m_sec == 0) begin
                m_pre = 0;
            end else if (m_pre == CF - 1) begin
                t = m_min * 60 + m_sec - 1;
                m_min = t / 60; m_sec = t % 60;
                m_pre = 0; m_tick = 1'b1;
            end else begin
                m_pre++;
            end
        end
    endtask

    task automatic check_all();
        chk("min_tens", 32'(bus.min_tens), 32'(m_min / 10));
        chk("min_ones", 32'(bus.min_ones), 32'(m_min % 10));
        chk("sec_tens", 32'(bus.sec_tens), 32'(m_sec / 10));
        chk("sec_ones", 32'(bus.sec_ones), 32'(m_sec % 10));
        chk("sec_tick", 32'(bus.sec_tick), 32'(m_tick));
        chk("complete", 32'(bus.complete), 32'(m_min == 0 && m_sec == 0));
    endtask

    task automatic cyc(input bit rst, input bit init, input bit cen,
                       input bit i, input bit d, input bit mn);
        @(negedge clk);
        reset             = rst;
        bus.init_regs     = init;
        bus.count_enabled = cen;
        bus.inc           = i;
        bus.dec           = d;
        bus.min           = mn;
        @(posedge clk);
        model_step(rst, init, cen, i, d, mn);
        #1;
        check_all();
    endtask

    task automatic chk_time(input string tag, input int mm, input int ss);
        chk(tag, 32'({bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones}),
            32'(((mm / 10) << 12) | ((mm % 10) << 8) | ((ss / 10) << 4) | (ss % 10)));
    endtask

    initial begin
        reset = 1'b1;
        bus.init_regs = 1'b0; bus.count_enabled = 1'b0;
        bus.inc = 1'b0; bus.dec = 1'b0; bus.min = 1'b0;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk_time("reset_time", 1, 0);
        chk("reset_complete", 32'(bus.complete), 0);
        chk("reset_tick", 32'(bus.sec_tick), 0);

        // Field edits with wrap, no cross-field carry
        cyc(0, 0, 0, 0, 1, 0);
        chk_time("sec_dec_wrap", 1, 59);
        cyc(0, 0, 0, 1, 0, 0);
        chk_time("sec_inc_wrap", 1, 0);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);
        chk_time("min_dec_wrap", 99, 0);
        cyc(0, 0, 1, 1, 1, 1);
        chk_time("inc_dec_both", 99, 0);
        for (int k = 0; k < 9; k++) cyc(0, 0, 0, 1, 0, 0);
        chk_time("sec_bcd_carry", 99, 9);
        cyc(0, 0, 0, 1, 0, 0);
        chk_time("sec_bcd_carry2", 99, 10);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0);
        chk_time("init_restore", 1, 0);

        // 01:00 -> 00:59 after exactly CF cycles, next tick CF later
        for (int k = 0; k < CF - 1; k++) cyc(0, 0, 1, 0, 0, 0);
        chk("t3_no_tick_early", 32'(bus.sec_tick), 0);
        chk_time("t3_still_0100", 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("t3_tick", 32'(bus.sec_tick), 1);
        chk_time("t3_0059", 0, 59);
        for (int k = 0; k < CF - 1; k++) cyc(0, 0, 1, 0, 0, 0);
        chk("t3_no_tick2", 32'(bus.sec_tick), 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk_time("t3_0058", 0, 58);

        // 00:02 down to 00:00, then hold
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk_time("t4_start", 0, 2);
        for (int k = 0; k < CF; k++) cyc(0, 0, 1, 0, 0, 0);
        chk_time("t4_0001", 0, 1);
        for (int k = 0; k < CF; k++) cyc(0, 0, 1, 0, 0, 0);
        chk_time("t4_0000", 0, 0);
        chk("t4_complete", 32'(bus.complete), 1);
        for (int k = 0; k < 30; k++) cyc(0, 0, 1, 0, 0, 0);
        chk_time("t4_hold", 0, 0);
        chk("t4_complete_hold", 32'(bus.complete), 1);

        // Pause preserves the partial second
        cyc(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 20; k++) cyc(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0, 0, 0);
        chk_time("t5_before", 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("t5_tick", 32'(bus.sec_tick), 1);
        chk_time("t5_after", 0, 59);

        // Mid-second init and reset restart the prescaler
        for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk_time("t6_init", 1, 0);
        for (int k = 0; k < CF - 1; k++) cyc(0, 0, 1, 0, 0, 0);
        chk_time("t6_init_full", 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk_time("t6_init_dec", 0, 59);
        for (int k = 0; k < 7; k++) cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        chk_time("t6_reset", 1, 0);
        chk("t6_reset_tick", 32'(bus.sec_tick), 0);
        for (int k = 0; k < CF - 1; k++) cyc(0, 0, 1, 0, 0, 0);
        chk_time("t6_reset_full", 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk_time("t6_reset_dec", 0, 59);

        // Random mix against the reference model
        for (int k = 0; k < 800; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            cyc(r == 0, r == 1, $urandom_range(0, 9) != 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
